// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// datapath mux selects, trap codes and the opcode classifier.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpArithR = 7'b0110011;
  localparam logic [6:0] OpArithI = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StHalt   = 3'd6;

  localparam logic [1:0] PcSrcPlus4  = 2'b00;
  localparam logic [1:0] PcSrcOldImm = 2'b01;
  localparam logic [1:0] PcSrcAlu    = 2'b10;

  localparam logic [1:0] AluASelRs1   = 2'b00;
  localparam logic [1:0] AluASelOldPc = 2'b01;
  localparam logic [1:0] AluASelZero  = 2'b10;

  localparam logic [1:0] AluBSelRs2  = 2'b00;
  localparam logic [1:0] AluBSelImm  = 2'b01;
  localparam logic [1:0] AluBSelFour = 2'b10;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpFunct = 2'b01;
  localparam logic [1:0] AluOpCmp   = 2'b10;

  localparam logic [1:0] TrapNone       = 2'b00;
  localparam logic [1:0] TrapIllegal    = 2'b01;
  localparam logic [1:0] TrapMemTimeout = 2'b10;

  typedef enum logic [3:0] {
    ClsIllegal,
    ClsArithR,
    ClsArithI,
    ClsLoad,
    ClsStore,
    ClsLui,
    ClsAuipc,
    ClsJal,
    ClsJalr,
    ClsBranch,
    ClsSystem
  } op_class_e;

  function automatic op_class_e classify(input logic [6:0] op);
    case (op)
      OpArithR: return ClsArithR;
      OpArithI: return ClsArithI;
      OpLoad:   return ClsLoad;
      OpStore:  return ClsStore;
      OpLui:    return ClsLui;
      OpAuipc:  return ClsAuipc;
      OpJal:    return ClsJal;
      OpJalr:   return ClsJalr;
      OpBranch: return ClsBranch;
      OpSystem: return ClsSystem;
      default:  return ClsIllegal;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared-memory request bus between the controller (master) and the memory (slave).
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_mem_watchdog.sv
// Counts consecutive unanswered memory-request cycles and flags a timeout on the
// last allowed one; TIMEOUT_CYCLES = 0 ties the timeout off.
module multicycle_ctrl_mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mem_req_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  localparam int unsigned CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LastCnt = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            waiting;

  assign waiting = mem_req_i & ~mem_ready_i;

  always_comb begin
    cnt_d = '0;
    if ((TIMEOUT_CYCLES != 0) && waiting) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // The cycle that would bring the count to TIMEOUT_CYCLES is the one that trips;
  // a ready in that same cycle masks it through 'waiting'.
  assign timeout_o = (TIMEOUT_CYCLES != 0) && waiting && (cnt_q == CntW'(LastCnt));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM of the multi-cycle RV32I core: sequences fetch, decode, execute,
// memory and write-back, with a memory watchdog, retire counter and sticky halt/trap.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_if.master    bus,
  input  logic [6:0]           opcode_i,
  input  logic                 branch_taken_i,
  output logic                 ir_we_o,
  output logic                 pc_we_o,
  output logic [1:0]           pc_src_o,
  output logic [1:0]           alu_a_sel_o,
  output logic [1:0]           alu_b_sel_o,
  output logic [1:0]           alu_op_o,
  output logic                 rf_we_o,
  output logic                 wb_sel_o,
  output logic                 halted_o,
  output logic [1:0]           trap_o,
  output logic [CNT_W-1:0]     instret_o
);

  logic [2:0]       state_q, state_d;
  logic             halted_q, halted_d;
  logic [1:0]       trap_q, trap_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  logic             timeout;
  logic             mem_req, mem_we, addr_sel;
  op_class_e        cls;

  assign cls = classify(opcode_i);

  multicycle_ctrl_mem_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_mem_watchdog (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mem_req_i   (mem_req),
    .mem_ready_i (bus.mem_ready),
    .timeout_o   (timeout)
  );

  always_comb begin
    state_d     = state_q;
    halted_d    = halted_q;
    trap_d      = trap_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_src_o    = PcSrcPlus4;
    alu_a_sel_o = AluASelRs1;
    alu_b_sel_o = AluBSelRs2;
    alu_op_o    = AluOpAdd;
    rf_we_o     = 1'b0;
    wb_sel_o    = 1'b0;
    retire      = 1'b0;

    case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_we_o = 1'b1;
          state_d = StDecode;
        end else if (timeout) begin
          trap_d  = TrapMemTimeout;
          state_d = StHalt;
        end
      end

      StDecode: begin
        if (cls == ClsIllegal) begin
          trap_d  = TrapIllegal;
          state_d = StHalt;
        end else if (cls == ClsSystem) begin
          halted_d = 1'b1;
          state_d  = StHalt;
        end else begin
          state_d = StExec;
        end
      end

      StExec: begin
        state_d = StWb;
        case (cls)
          ClsArithR: alu_op_o = AluOpFunct;
          ClsArithI: begin
            alu_b_sel_o = AluBSelImm;
            alu_op_o    = AluOpFunct;
          end
          ClsLoad, ClsStore: begin
            alu_b_sel_o = AluBSelImm;
            state_d     = StMem;
          end
          ClsLui: begin
            alu_a_sel_o = AluASelZero;
            alu_b_sel_o = AluBSelImm;
          end
          ClsAuipc: begin
            alu_a_sel_o = AluASelOldPc;
            alu_b_sel_o = AluBSelImm;
          end
          ClsJal, ClsJalr: begin
            alu_a_sel_o = AluASelOldPc;
            alu_b_sel_o = AluBSelFour;
          end
          ClsBranch: begin
            alu_op_o = AluOpCmp;
            pc_we_o  = 1'b1;
            pc_src_o = branch_taken_i ? PcSrcOldImm : PcSrcPlus4;
            retire   = 1'b1;
            state_d  = StFetch;
          end
          default: ;
        endcase
      end

      StMem: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls == ClsStore);
        if (bus.mem_ready) begin
          if (cls == ClsStore) begin
            pc_we_o = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timeout) begin
          trap_d  = TrapMemTimeout;
          state_d = StHalt;
        end
      end

      StWb: begin
        rf_we_o  = 1'b1;
        wb_sel_o = (cls == ClsLoad);
        pc_we_o  = 1'b1;
        retire   = 1'b1;
        state_d  = StFetch;
        case (cls)
          ClsJal:  pc_src_o = PcSrcOldImm;
          // Link value already sits in ALU-out; the ALU now forms the jump target.
          ClsJalr: begin
            pc_src_o    = PcSrcAlu;
            alu_b_sel_o = AluBSelImm;
          end
          default: ;
        endcase
      end

      StHalt: ;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      halted_q  <= 1'b0;
      trap_q    <= TrapNone;
      instret_q <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      trap_q   <= trap_d;
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign bus.mem_req  = mem_req;
  assign bus.mem_we   = mem_we;
  assign bus.addr_sel = addr_sel;
  assign halted_o     = halted_q;
  assign trap_o       = trap_q;
  assign instret_o    = instret_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM for the multi-cycle RV32I core.
- Sequences a single shared instruction/data memory, the IR, the PC, the ALU operand muxes, the register-file write and the immediate-generator-fed datapath, one instruction at a time.
- Adds a memory-wait watchdog, a retired-instruction counter and a sticky halt/trap state.

Parameters:
- TIMEOUT_CYCLES, 0, maximum cycles mem_req may wait for mem_ready before trapping; 0 disables the watchdog.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0], valid from DECODE onward.
- branch_taken  in  1  comparator result for the current branch, valid in EXEC.
- mem_ready  in  1  memory completion strobe.
- mem_req  out  1  memory request.
- mem_we  out  1  store when 1, read when 0.
- addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  load IR and old_pc.
- pc_we  out  1  PC write enable.
- pc_src  out  2  00 = PC+4, 01 = old_pc+imm, 10 = ALU result with bit0 cleared.
- alu_a_sel  out  2  00 = rs1, 01 = old_pc, 10 = zero.
- alu_b_sel  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = funct-decoded, 10 = compare.
- rf_we  out  1  register-file write enable.
- wb_sel  out  1  0 = ALU result, 1 = memory read data.
- halted  out  1  sticky halt after ECALL/EBREAK.
- trap  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout; sticky.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset, asynchronous, any state:
  - state goes to IDLE.
  - All outputs 0; instret 0; trap 00; watchdog count 0.
  - mem_req drops immediately; no partial writes are issued.
- IDLE: all outputs 0; goes to FETCH on the first clock edge with rst_n high.
- FETCH:
  - mem_req=1, addr_sel=0, mem_we=0.
  - Hold until mem_ready=1 is sampled at a rising edge.
  - In that cycle, ir_we=1 (Mealy); next state DECODE.
  - mem_ready outside FETCH/MEM is ignored.
- DECODE (1 cycle): register file read; opcode classified.
  - Unknown opcode: trap=01, go to HALT.
  - SYSTEM: halted=1, go to HALT.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - Arith_R: a=rs1, b=rs2, op=01, then WB.
  - Arith_I: a=rs1, b=imm, op=01, then WB.
  - Load/Store: a=rs1, b=imm, op=00, then MEM.
  - LUI: a=zero, b=imm, then WB.
  - AUIPC: a=old_pc, b=imm, then WB.
  - JAL/JALR: a=old_pc, b=4, then WB. The link value is latched by the datapath ALU-out register.
  - Branch: op=10; pc_we=1; pc_src=01 if branch_taken, else 00; retire; go to FETCH.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for Store.
  - These outputs stay stable until mem_ready is sampled.
  - Store completes with pc_we=1, pc_src=00, retire, then FETCH.
  - Load completes and goes to WB.
- WB (1 cycle):
  - rf_we=1; wb_sel=1 for Load, else 0; pc_we=1.
  - pc_src: 01 for JAL, 10 for JALR (ALU recomputed as rs1+imm in WB), else 00.
  - Retire; go to FETCH.
- HALT:
  - All strobes 0; halted and trap stay held.
  - Exit only via rst_n.
- Latency with zero-wait memory:
  - Branch: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR, Store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- Retire:
  - instret increments by exactly 1 on the retiring edge.
  - Wraps from all-ones to 0 without a flag.
- Watchdog:
  - Counts cycles with mem_req=1 and mem_ready=0; clears on handshake.
  - When the count reaches TIMEOUT_CYCLES (nonzero): trap=10, mem_req deasserts next cycle, go to HALT.
  - mem_ready arriving in the same cycle as the timeout wins: the handshake completes and no trap is raised.

Decomposition:
- defines.v (shared header) holds:
  - opcode constants (including Load, Arith_R, SYSTEM);
  - the state encoding: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT;
  - the pc_src, alu_*_sel and trap encodings.
- One sub-module, mem_watchdog: counter plus timeout compare, with TIMEOUT_CYCLES=0 tie-off.
- The FSM and output decode stay in multicycle_ctrl.

Test Plan:
- ADDI, zero-wait memory -> states FETCH, DECODE, EXEC, WB over 4 cycles; rf_we=1 only in WB; instret 0->1.
- LW with mem_ready low for 3 cycles in both FETCH and MEM -> 11 cycles total; addr_sel=1 and mem_we=0 stable throughout MEM; wb_sel=1 in WB.
- BEQ, branch_taken=1 then a second BEQ with branch_taken=0 -> pc_src 01 then 00; each branch takes 3 cycles; rf_we never asserted.
- opcode 7'b0000000 -> trap=01 and HALT after DECODE; outputs frozen for 20 cycles; rst_n pulse returns to IDLE with trap=00.
- TIMEOUT_CYCLES=8, mem_ready never asserted -> trap=10 after 8 wait cycles; mem_req low the next cycle. Repeat with mem_ready on cycle 8 -> no trap.
- rst_n asserted mid-MEM of SW -> mem_req and mem_we drop asynchronously before the next edge; IDLE, then FETCH; instret unchanged from its reset value 0.
